// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin two-port arbiter and full-array flush sequencer
// in front of a single-port SRAM macro.
//
// Ports:
//   clk_i, rst_i                    clock, async active-high reset
//   pN_req_i/we_i/addr_i/wdata_i    requester N access (N = 0, 1)
//   pN_gnt_o                        combinational grant, access issued now
//   pN_rvalid_o, rdata_o            read data return, one cycle after grant
//   flush_i, busy_o, flush_done_o   array clear start, in progress, done pulse
//   sram_req_o/we_o/addr_o/wdata_o  SRAM command, sram_rdata_i read data
module sram_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 1024,
  parameter int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  p0_req_i,
  input  logic                  p0_we_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [DATA_WIDTH-1:0] p0_wdata_i,
  output logic                  p0_gnt_o,
  output logic                  p0_rvalid_o,
  input  logic                  p1_req_i,
  input  logic                  p1_we_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [DATA_WIDTH-1:0] p1_wdata_i,
  output logic                  p1_gnt_o,
  output logic                  p1_rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  flush_done_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  // One extra bit so a power-of-two depth ends without wrapping.
  localparam logic [ADDR_WIDTH:0] CNT_LAST =
    (ADDR_WIDTH+1)'(NUM_WORDS - 1);

  state_t              state;
  logic [ADDR_WIDTH:0] cnt;
  // last = 1: port 1 was granted most recently, so port 0 wins a tie.
  logic                last;

  logic arb_en;
  logic win0;
  logic win1;
  logic flushing;

  // A flush request steals the cycle from both requesters.
  assign arb_en   = !rst_i && (state == IDLE) && !flush_i;
  assign win0     = arb_en && p0_req_i && (!p1_req_i || last);
  assign win1     = arb_en && p1_req_i && (!p0_req_i || !last);
  assign flushing = !rst_i && (state == FLUSH);

  assign p0_gnt_o = win0;
  assign p1_gnt_o = win1;
  assign busy_o   = (state == FLUSH);
  assign rdata_o  = sram_rdata_i;

  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    unique case (1'b1)
      flushing: begin
        sram_req_o  = 1'b1;
        sram_we_o   = 1'b1;
        sram_addr_o = cnt[ADDR_WIDTH-1:0];
      end
      win0: begin
        sram_req_o   = 1'b1;
        sram_we_o    = p0_we_i;
        sram_addr_o  = p0_addr_i;
        sram_wdata_o = p0_wdata_i;
      end
      win1: begin
        sram_req_o   = 1'b1;
        sram_we_o    = p1_we_i;
        sram_addr_o  = p1_addr_i;
        sram_wdata_o = p1_wdata_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      last         <= 1'b1;
      p0_rvalid_o  <= 1'b0;
      p1_rvalid_o  <= 1'b0;
      flush_done_o <= 1'b0;
    end else begin
      p0_rvalid_o  <= win0 && !p0_we_i;
      p1_rvalid_o  <= win1 && !p1_we_i;
      flush_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_i) begin
            state <= FLUSH;
            cnt   <= '0;
          end else if (win0) begin
            last <= 1'b0;
          end else if (win1) begin
            last <= 1'b1;
          end
        end
        FLUSH: begin
          cnt <= cnt + (ADDR_WIDTH+1)'(1);
          if (cnt == CNT_LAST) begin
            state        <= IDLE;
            flush_done_o <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized and directed checks of sram_arbiter against
// a behavioural model, with a small SRAM model attached to the DUT.
module tb_sram_arbiter;

  localparam int DW = 64;
  localparam int NW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DW-1:0] rdata;
  logic          flush, busy, flush_done;
  logic          sram_req, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;

  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] mem [NW];

  always #5 clk = ~clk;

  sram_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_WORDS (NW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .p0_req_i    (p0_req),
    .p0_we_i     (p0_we),
    .p0_addr_i   (p0_addr),
    .p0_wdata_i  (p0_wdata),
    .p0_gnt_o    (p0_gnt),
    .p0_rvalid_o (p0_rvalid),
    .p1_req_i    (p1_req),
    .p1_we_i     (p1_we),
    .p1_addr_i   (p1_addr),
    .p1_wdata_i  (p1_wdata),
    .p1_gnt_o    (p1_gnt),
    .p1_rvalid_o (p1_rvalid),
    .rdata_o     (rdata),
    .flush_i     (flush),
    .busy_o      (busy),
    .flush_done_o(flush_done),
    .sram_req_o  (sram_req),
    .sram_we_o   (sram_we),
    .sram_addr_o (sram_addr),
    .sram_wdata_o(sram_wdata),
    .sram_rdata_i(sram_rdata)
  );

  // SRAM macro model with a preload path used only during reset.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (sram_req) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else sram_rdata <= mem[sram_addr];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: words left to clear, last winner, returns pending.
  logic [DW-1:0] shadow [NW];
  int            m_left;
  int            m_last;
  bit            m_rv0, m_rv1, m_done;
  logic [DW-1:0] m_rdata;
  int            m_w;
  int            done_cnt;

  task automatic model_reset();
    m_left = 0;
    m_last = 1;
    m_rv0  = 0;
    m_rv1  = 0;
    m_done = 0;
  endtask

  function automatic int winner();
    if (rst || m_left != 0 || flush) return -1;
    if (p0_req && p1_req) return (m_last == 0) ? 1 : 0;
    if (p0_req) return 0;
    if (p1_req) return 1;
    return -1;
  endfunction

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    logic          ereq, ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd;
    #1;
    m_w   = winner();
    ereq  = 0;
    ewe   = 0;
    eaddr = '0;
    ewd   = '0;
    if (!rst && m_left > 0) begin
      ereq  = 1;
      ewe   = 1;
      eaddr = AW'(NW - m_left);
    end else if (m_w == 0) begin
      ereq  = 1;
      ewe   = p0_we;
      eaddr = p0_addr;
      ewd   = p0_wdata;
    end else if (m_w == 1) begin
      ereq  = 1;
      ewe   = p1_we;
      eaddr = p1_addr;
      ewd   = p1_wdata;
    end
    check("p0_gnt", DW'(p0_gnt), DW'(m_w == 0));
    check("p1_gnt", DW'(p1_gnt), DW'(m_w == 1));
    check("sram_req", DW'(sram_req), DW'(ereq));
    check("sram_we", DW'(sram_we), DW'(ewe));
    check("sram_addr", DW'(sram_addr), DW'(eaddr));
    check("sram_wdata", sram_wdata, ewd);
    check("busy", DW'(busy), DW'(m_left > 0));
    check("p0_rvalid", DW'(p0_rvalid), DW'(m_rv0));
    check("p1_rvalid", DW'(p1_rvalid), DW'(m_rv1));
    check("flush_done", DW'(flush_done), DW'(m_done));
    if (m_rv0 || m_rv1) check("rdata", rdata, m_rdata);
    if (flush_done) done_cnt++;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_rv0  = (m_w == 0) && !p0_we;
      m_rv1  = (m_w == 1) && !p1_we;
      m_done = (m_left == 1);
      if (m_left > 0) begin
        shadow[NW - m_left] = '0;
        m_left--;
      end else if (flush) begin
        m_left = NW;
      end else if (m_w >= 0) begin
        if (ewe) shadow[eaddr] = ewd;
        else m_rdata = shadow[eaddr];
        m_last = m_w;
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_ports();
    if (!p0_req || m_w == 0) begin
      p0_req   = ($urandom_range(0, 3) != 0);
      p0_we    = $urandom_range(0, 1) == 1;
      p0_addr  = AW'($urandom);
      p0_wdata = {$urandom, $urandom};
    end
    if (!p1_req || m_w == 1) begin
      p1_req   = ($urandom_range(0, 3) != 0);
      p1_we    = $urandom_range(0, 3) == 0;
      p1_addr  = AW'($urandom);
      p1_wdata = {$urandom, $urandom};
    end
  endtask

  initial begin
    rst = 1;
    {p0_req, p0_we, p1_req, p1_we, flush} = '0;
    p0_addr = '0; p1_addr = '0;
    p0_wdata = '0; p1_wdata = '0;
    pre_we = 0; pre_addr = '0; pre_data = '0;
    done_cnt = 0;
    m_w = -1;
    m_rdata = '0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < NW; i++) begin
      pre_we    = 1;
      pre_addr  = AW'(i);
      pre_data  = (i == 5) ? DW'(64'hA5) : {$urandom, $urandom};
      shadow[i] = pre_data;
      @(negedge clk);
    end
    pre_we = 0;
    step();
    rst = 0;

    // Contention from reset: p0, p1, p0, p1.
    p0_req = 1; p0_addr = 4'd1;
    p1_req = 1; p1_addr = 4'd2;
    for (int i = 0; i < 4; i++) begin
      step();
      check("contention_gnt", DW'(m_w), DW'(i % 2));
    end
    p0_req = 0; p1_req = 0;
    step();

    // Single read of addr 5.
    p1_req = 1; p1_addr = 4'd5;
    step();
    p1_req = 0;
    step();
    check("single_read", m_rdata, DW'(64'hA5));

    // Write then read.
    p0_req = 1; p0_we = 1; p0_addr = 4'd3; p0_wdata = DW'(64'h1234);
    step();
    p0_req = 0; p0_we = 0;
    p1_req = 1; p1_addr = 4'd3;
    step();
    p1_req = 0;
    step();
    check("write_read", m_rdata, DW'(64'h1234));

    // Flush with p1 pending.
    done_cnt = 0;
    flush = 1; p1_req = 1; p1_addr = 4'd9;
    step();
    flush = 0;
    for (int i = 0; i < NW; i++) step();
    step();
    check("flush_gnt_at_done", DW'(m_w), DW'(1));
    p1_req = 0;
    step();
    check("flush_done_count", DW'(done_cnt), DW'(1));
    for (int i = 0; i < 3; i++) begin
      p0_req = 1; p0_addr = AW'($urandom);
      step();
    end
    p0_req = 0;
    step();
    check("read_after_flush", m_rdata, '0);

    // Reset at flush address 7.
    flush = 1;
    step();
    flush = 0;
    for (int i = 0; i < 7; i++) step();
    check("mid_flush_addr", DW'(sram_addr), DW'(7));
    p0_req = 1; p0_addr = 4'd2;
    rst = 1;
    model_reset();
    step();
    step();
    rst = 0;
    done_cnt = 0;
    step();
    check("post_reset_gnt", DW'(p0_gnt), DW'(1));
    p0_req = 0;
    step();
    check("no_done_after_rst", DW'(done_cnt), DW'(0));

    // Flush held high across the whole flush.
    done_cnt = 0;
    flush = 1;
    for (int i = 0; i < NW + 2; i++) step();
    check("held_flush_done", DW'(done_cnt), DW'(1));
    step();
    check("second_flush_busy", DW'(busy), DW'(1));
    flush = 0;
    for (int i = 0; i < NW; i++) step();

    // Random traffic with occasional flushes and resets.
    for (int i = 0; i < 800; i++) begin
      rand_ports();
      flush = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1;
        model_reset();
        step();
        rst = 0;
      end
      step();
    end
    flush = 0; p0_req = 0; p1_req = 0;
    for (int i = 0; i < NW + 2; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and flush sequencer in front of the single-port `sram` macro used by the instruction cache. It shares the SRAM between a refill requester (port 0, typically writes) and a lookup requester (port 1, typically reads) with round-robin priority. It also clears the whole array on request by sequencing one zero-write per cycle. It sits between the cache controller and the `sram` instance, and drives that instance's `req_i`/`we_i`/`addr_i`/`wdata_i` directly.

## Interface
- `DATA_WIDTH`, 64: SRAM word width.
- `NUM_WORDS`, 1024: SRAM depth.
- `ADDR_WIDTH`, $clog2(NUM_WORDS): address width.

- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, asynchronous and active-high.
- `p0_req_i`, `p1_req_i` in 1 each: access request, held until granted.
- `p0_we_i`, `p1_we_i` in 1 each: 1 = write, 0 = read.
- `p0_addr_i`, `p1_addr_i` in ADDR_WIDTH each: word address.
- `p0_wdata_i`, `p1_wdata_i` in DATA_WIDTH each: write data.
- `p0_gnt_o`, `p1_gnt_o` out 1 each: combinational grant; the access is issued to the SRAM in this cycle.
- `p0_rvalid_o`, `p1_rvalid_o` out 1 each: registered; read data valid for that port.
- `rdata_o` out DATA_WIDTH: read data, equal to `sram_rdata_i`; meaningful only while an rvalid is high.
- `flush_i` in 1: start a full-array clear.
- `busy_o` out 1: high while flushing.
- `flush_done_o` out 1: registered single-cycle pulse when a flush completes.
- `sram_req_o`, `sram_we_o` out 1 each: SRAM request and write enable.
- `sram_addr_o` out ADDR_WIDTH: SRAM address.
- `sram_wdata_o` out DATA_WIDTH: SRAM write data.
- `sram_rdata_i` in DATA_WIDTH: SRAM read data, valid one cycle after the read request edge.

## Operation
- States: IDLE and FLUSH. Reset state is IDLE.
- In IDLE, arbitration:
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port not granted most recently is granted.
  - Priority pointer `last` resets to 1, so port 0 wins the first tie.
  - `last` updates only on a grant.
- Granted access: `sram_req_o`=1, and `sram_we_o`/`sram_addr_o`/`sram_wdata_o` are muxed from the winning port.
- No grant: `sram_req_o`=0 and all other SRAM outputs are 0.
- Granted read: the `pN_rvalid_o` flop is set for the next cycle only.
- Granted write: produces no rvalid.
- `flush_i` in IDLE:
  - No grant is issued that cycle, even if ports are requesting.
  - Flush counter `cnt` is cleared to 0 and the state moves to FLUSH.
  - flush_i has priority over both ports.
- In FLUSH, each cycle:
  - `sram_req_o`=1, `sram_we_o`=1, `sram_addr_o`=`cnt`, `sram_wdata_o`=0.
  - `cnt` increments.
  - Both grants are 0.
  - `flush_i` is ignored.
- When `cnt`==NUM_WORDS-1 in FLUSH: the next state is IDLE and `flush_done_o` pulses for that first IDLE cycle.
- `busy_o` = (state==FLUSH).
- Requesters keep their requests asserted across a flush. They are served in IDLE after the flush, starting with the `flush_done_o` cycle.

## Timing
- Reset values: state IDLE, `cnt`=0, `last`=1, all rvalid 0, `flush_done_o`=0.
- While `rst_i` is high, all grants and `sram_req_o` are forced to 0.
- Grant latency: 0 cycles, same cycle as the request when the port wins.
- Read latency: `pN_rvalid_o` and `rdata_o` are valid exactly 1 cycle after the grant.
- Back-to-back grants are allowed every cycle. Throughput is one access per cycle.
- Flush duration: exactly NUM_WORDS SRAM write cycles, plus the 1 cycle in which `flush_i` was accepted.
- A read granted in the cycle before `flush_i` is accepted still returns its rvalid in the acceptance cycle.
- Reset mid-flush:
  - Returns immediately to IDLE with `cnt`=0.
  - No `flush_done_o` pulse.
  - Partially cleared contents are not the arbiter's concern.
- `cnt` is ADDR_WIDTH+1 bits wide, so NUM_WORDS equal to a power of two terminates without wrap.

## Test plan
- Single read (NUM_WORDS=16):
  - Stimulus: p1 read of addr 5 holding 0xA5.
  - Required: `p1_gnt_o`=1 in the same cycle, `sram_addr_o`=5, `sram_we_o`=0; next cycle `p1_rvalid_o`=1 and `rdata_o`=0xA5; `p0_rvalid_o` stays 0.
- Contention, both ports requesting continuously for 4 cycles from reset:
  - Required: grant sequence p0, p1, p0, p1.
  - Required: rvalids follow one cycle later on the matching ports only.
- Write then read:
  - Stimulus: p0 writes 0x1234 to addr 3, then p1 reads addr 3.
  - Required: `p1_rvalid_o` with `rdata_o`=0x1234.
- Flush with pending request (NUM_WORDS=16):
  - Stimulus: `flush_i` pulsed while p1_req is high.
  - Required: no grant for 17 cycles; `busy_o` high for 16; `sram_addr_o` runs 0..15 with `sram_wdata_o`=0.
  - Required: `flush_done_o` pulses once and `p1_gnt_o`=1 in that same cycle; a later read of any address returns 0.
- Reset mid-flush:
  - Stimulus: assert `rst_i` at flush address 7.
  - Required: `busy_o`=0 and grants forced 0 during reset; after release, state IDLE, no `flush_done_o`, and a p0 request is granted immediately.
- Ignored flush:
  - Stimulus: `flush_i` held high for the whole flush.
  - Required: exactly one `flush_done_o`; then IDLE accepts `flush_i` again and starts a second flush.
